hw1_1_vec_checker: RTL and testbench
====================================

// Module: hw1_1_vec_checker
// PURPOSE
//  On-chip stimulus/response checker for the 7-input/1-output hw1_1 gate.
//  Drives vectors {A,B,C,D,E,F,G} into the gate, waits a settle window, samples O
//  and compares it with the expected value. Reports the mismatch count, the first
//  failing index and pass/done. Sits beside the gate on the board top; LEDs show the result.
// PARAMETERS
//  N_VEC       5    number of directed vectors in the ROM
//  SETTLE_CYC  10   clocks between applying a vector and sampling O (>=1)
//  CNT_W       8    width of the fail counter (saturating)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  start     in   1      one-cycle pulse; starts a run from IDLE or DONE
//  vec_out   out  7      {A,B,C,D,E,F,G} driven into the gate; reset 7'b0
//  dut_o     in   1      gate output O
//  busy      out  1      high from start acceptance until DONE; reset 0
//  done      out  1      high in DONE until the next start or rst; reset 0
//  pass      out  1      done && fail_cnt==0; reset 0
//  fail_cnt  out  CNT_W  number of mismatches, saturates at all-ones; reset 0
//  fail_idx  out  7      index of the first mismatch, valid when fail_cnt!=0; reset 0
// BEHAVIOUR
//  - FSM states: IDLE, APPLY, SETTLE, CHECK, DONE. Reset enters IDLE from any state.
//  - IDLE/DONE + start: idx<=0, fail_cnt<=0, fail_idx<=0, done<=0, busy<=1, go to APPLY.
//  - APPLY (1 clk): vec_out<=VEC[idx]; load settle timer with SETTLE_CYC; go to SETTLE.
//  - SETTLE (SETTLE_CYC clks): vec_out held stable; go to CHECK when the timer expires.
//  - CHECK (1 clk): compare dut_o with EXP[idx].
//    * On mismatch: fail_cnt+1 (saturating).
//    * On the first mismatch: fail_idx<=idx.
//    * If idx==N_VEC-1: go to DONE. Otherwise idx+1 and go to APPLY.
//  - DONE: busy=0, done=1, vec_out holds the last vector; state remains DONE until start.
//  - Latency: the DONE edge is N_VEC*(SETTLE_CYC+2) clks after the edge that samples start.
//    Default: 60 clks.
//  - start while busy: ignored, with no effect on the run.
//  - rst mid-run: next edge gives IDLE with all outputs at their reset values; no partial result kept.
//  - Directed ROM (idx: vec -> exp):
//    0: 0000000->1; 1: 0000001->0; 2: 0000000->1; 3: 0000110->0; 4: 1100001->1.
// CONFIGURATION
//  - HW1_1_EXHAUSTIVE_EN defined: the ROM is bypassed. idx sweeps 0..127, vec_out=idx[6:0],
//    and the expected value is the package golden function gate_ref(vec).
//    The run length is 128 vectors; latency is 128*(SETTLE_CYC+2).
//  - HW1_1_EXHAUSTIVE_EN undefined: the N_VEC directed ROM above is used; gate_ref is not used.
// STRUCTURE
//  - Package hw1_pkg:
//    * state enum (IDLE, APPLY, SETTLE, CHECK, DONE)
//    * VEC/EXP constant tables
//    * VEC_W=7
//    * function gate_ref, which must match hw1_1_gate
//  - Sub-module hw1_settle_timer: down-counter with load/expire, width $clog2(SETTLE_CYC+1).
// TESTING (bench instantiates the checker and hw1_1_gate; dut_o may be forced)
//  - Test 1, reset: hold rst for 3 clks -> busy=0, done=0, pass=0, fail_cnt=0, vec_out=0.
//  - Test 2, good gate: start pulse -> done rises 60 clks later, pass=1, fail_cnt=0;
//    vec_out steps through the 5 ROM vectors.
//  - Test 3, faulty gate: force dut_o=1 -> vectors 1 and 3 mismatch, giving fail_cnt=2,
//    fail_idx=1, pass=0.
//  - Test 4, start while busy: pulse start at clk 20 of a run -> done still at clk 60;
//    results are the same as in Test 2.
//  - Test 5, reset mid-run: rst at clk 30, then start -> a clean run; done 60 clks after
//    the second start; fail_cnt holds nothing from the first run.
//  - Test 6, exhaustive (HW1_1_EXHAUSTIVE_EN): start -> done after 1536 clks, pass=1;
//    with dut_o forced to 0, fail_cnt equals the count of gate_ref==1 vectors.

Source files
------------

// File: rtl/hw1_pkg.sv
// Shared types, directed vector ROM and golden model for the hw1_1 checker.
// The HW1_1_EXHAUSTIVE_EN build uses gate_ref instead of the ROM.
package hw1_pkg;

  localparam int VEC_W = 7;
  localparam int N_VEC = 5;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [VEC_W-1:0] VEC [N_VEC] = '{
    7'b0000000,
    7'b0000001,
    7'b0000000,
    7'b0000110,
    7'b1100001
  };

  // bit i is the expected O for VEC[i]
  localparam logic [N_VEC-1:0] EXP = 5'b10101;

  function automatic logic gate_ref(input logic [VEC_W-1:0] v);
    return (v[6] & v[5]) | ~(|v[4:0]);
  endfunction

endpackage

// File: rtl/hw1_settle_timer.sv
// Settle-window down-counter: load sets it to INIT, expire flags the
// last counting cycle so the next state can be entered on time.
module hw1_settle_timer #(
  parameter int INIT = 10,
  parameter int W    = $clog2(INIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(INIT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/hw1_1_vec_checker.sv
// On-chip stimulus/response checker for the hw1_1 gate.
// Define HW1_1_EXHAUSTIVE_EN to sweep all 128 inputs against gate_ref.
module hw1_1_vec_checker
  import hw1_pkg::*;
#(
  parameter int N_VEC      = hw1_pkg::N_VEC,
  parameter int SETTLE_CYC = 10,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [VEC_W-1:0] vec_out,
  input  logic             dut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [6:0]       fail_idx
);

`ifdef HW1_1_EXHAUSTIVE_EN
  localparam int N_RUN = 128;
`else
  localparam int N_RUN = N_VEC;
  localparam int IW    = $clog2(N_VEC);
`endif
  localparam logic [6:0] LAST = 7'(N_RUN - 1);

  state_t           state;
  logic [6:0]       idx;
  logic [VEC_W-1:0] vec_cur;
  logic             exp_bit;
  logic             mismatch;
  logic             t_exp;

  always_comb begin
`ifdef HW1_1_EXHAUSTIVE_EN
    vec_cur = idx;
    exp_bit = gate_ref(idx);
`else
    vec_cur = VEC[idx[IW-1:0]];
    exp_bit = EXP[idx[IW-1:0]];
`endif
    mismatch = (dut_o != exp_bit);
  end

  hw1_settle_timer #(
    .INIT (SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == APPLY),
    .en     (state == SETTLE),
    .expire (t_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      vec_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_cnt <= '0;
      fail_idx <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            idx      <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            state    <= APPLY;
          end
        end
        APPLY: begin
          vec_out <= vec_cur;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (t_exp) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == '0) fail_idx <= idx;
          end
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt == '0) && !mismatch;
            state <= DONE;
          end else begin
            idx   <= idx + 7'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hw1_1_vec_checker.sv
// Randomized self-checking bench for hw1_1_vec_checker.
// Gate output is modelled here; HW1_1_EXHAUSTIVE_EN selects the sweep build.
module tb_hw1_1_vec_checker;

  localparam int SETTLE = 10;
  localparam int P      = SETTLE + 2;
`ifdef HW1_1_EXHAUSTIVE_EN
  localparam int NV = 128;
`else
  localparam int NV = 5;
`endif

  localparam logic [6:0] ROM [5] = '{
    7'b0000000, 7'b0000001, 7'b0000000, 7'b0000110, 7'b1100001
  };
  localparam logic [4:0] ROM_EXP = 5'b10101;

  logic       clk = 1'b0;
  logic       rst, start, dut_o;
  logic [6:0] vec_out, fail_idx, s_vec, s_fidx;
  logic       busy, done, pass, s_busy, s_done, s_pass;
  logic [7:0] fail_cnt;
  logic [0:0] s_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit flip [128];
  int force_val = -1;

  always #5 clk = ~clk;

  hw1_1_vec_checker #(
    .N_VEC(5), .SETTLE_CYC(SETTLE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_out),
    .dut_o(dut_o), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .fail_idx(fail_idx)
  );

  // narrow counter instance to observe saturation
  hw1_1_vec_checker #(
    .N_VEC(5), .SETTLE_CYC(SETTLE), .CNT_W(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .vec_out(s_vec),
    .dut_o(dut_o), .busy(s_busy), .done(s_done), .pass(s_pass),
    .fail_cnt(s_cnt), .fail_idx(s_fidx)
  );

  function automatic logic gate_model(input logic [6:0] v);
    return (v[6:5] == 2'b11) || (v[4:0] == 5'd0);
  endfunction

  function automatic logic [6:0] vec_of(input int k);
`ifdef HW1_1_EXHAUSTIVE_EN
    return 7'(k);
`else
    return ROM[k];
`endif
  endfunction

  function automatic logic exp_of(input int k);
`ifdef HW1_1_EXHAUSTIVE_EN
    return gate_model(vec_of(k));
`else
    return ROM_EXP[k];
`endif
  endfunction

  function automatic logic obs_of(input int k);
    if (force_val >= 0) return force_val[0];
    return gate_model(vec_of(k)) ^ flip[k];
  endfunction

  task automatic expect_run(output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int k = 0; k < NV; k++) begin
      if (obs_of(k) != exp_of(k)) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
  endtask

  // Starts a run and plays the gate; reports the edge on which done rose.
  task automatic drive_run(input int extra_start, output int done_at,
                           output int vec_errs);
    int kk;
    done_at  = -1;
    vec_errs = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < NV * P + 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 1 && done) begin
        done_at = c;
        break;
      end
      if (c >= 1) begin
        kk = (c - 1) / P;
        if (vec_out !== vec_of(kk)) vec_errs++;
      end
      if (c + 1 == extra_start) start = 1'b1;
      kk = c / P;
      if (kk > NV - 1) kk = NV - 1;
      if (force_val >= 0) dut_o = force_val[0];
      else dut_o = gate_model(vec_out) ^ flip[kk];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dut_o = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if (pass !== 1'b0) begin
      n_fail++; $display("FAIL reset_pass: got %b want 0", pass);
    end
    n_cmp++;
    if (fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt);
    end
    n_cmp++;
    if (vec_out !== 7'd0) begin
      n_fail++; $display("FAIL reset_vec_out: got %b want 0", vec_out);
    end
    n_cmp++;
    if (fail_idx !== 7'd0) begin
      n_fail++; $display("FAIL reset_fail_idx: got %0d want 0", fail_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_good_gate();
    int d, ve;
    force_val = -1;
    foreach (flip[i]) flip[i] = 1'b0;
    drive_run(-1, d, ve);
    n_cmp++;
    if (d != NV * P) begin
      n_fail++; $display("FAIL good_latency: got %0d want %0d", d, NV * P);
    end
    n_cmp++;
    if (pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL good_pass: got pass=%b busy=%b want 1/0",
                         pass, busy);
    end
    n_cmp++;
    if (fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL good_fail_cnt: got %0d want 0", fail_cnt);
    end
    n_cmp++;
    if (ve != 0) begin
      n_fail++; $display("FAIL good_vec_seq: got %0d bad cycles want 0", ve);
    end
  endtask

  task automatic test_faulty_gate();
    int d, ve, ec, ei;
    force_val = 1;
    expect_run(ec, ei);
    drive_run(-1, d, ve);
    n_cmp++;
    if (fail_cnt !== 8'(ec)) begin
      n_fail++; $display("FAIL fault_cnt: got %0d want %0d", fail_cnt, ec);
    end
    n_cmp++;
    if (fail_idx !== 7'(ei)) begin
      n_fail++; $display("FAIL fault_idx: got %0d want %0d", fail_idx, ei);
    end
    n_cmp++;
    if (pass !== (ec == 0)) begin
      n_fail++; $display("FAIL fault_pass: got %b want %b", pass, ec == 0);
    end
    n_cmp++;
    if (s_cnt !== 1'(ec > 0) || s_pass !== (ec == 0)) begin
      n_fail++; $display("FAIL fault_sat: got cnt=%0d pass=%b want %0d/%b",
                         s_cnt, s_pass, ec > 0, ec == 0);
    end
    force_val = -1;
  endtask

  task automatic test_start_while_busy();
    int d, ve;
    force_val = -1;
    foreach (flip[i]) flip[i] = 1'b0;
    drive_run(20, d, ve);
    n_cmp++;
    if (d != NV * P) begin
      n_fail++; $display("FAIL busy_start_latency: got %0d want %0d",
                         d, NV * P);
    end
    n_cmp++;
    if (pass !== 1'b1 || fail_cnt !== 8'd0) begin
      n_fail++; $display("FAIL busy_start_result: got pass=%b cnt=%0d want 1/0",
                         pass, fail_cnt);
    end
    n_cmp++;
    if (ve != 0) begin
      n_fail++; $display("FAIL busy_start_vec_seq: got %0d want 0", ve);
    end
  endtask

  task automatic test_reset_mid_run();
    int d, ve;
    @(negedge clk);
    start = 1'b1;
    dut_o = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: got b=%b d=%b p=%b want 0/0/0",
                         busy, done, pass);
    end
    n_cmp++;
    if (fail_cnt !== 8'd0 || vec_out !== 7'd0 || fail_idx !== 7'd0) begin
      n_fail++; $display("FAIL midrst_regs: got cnt=%0d vec=%b idx=%0d want 0",
                         fail_cnt, vec_out, fail_idx);
    end
    force_val = -1;
    foreach (flip[i]) flip[i] = 1'b0;
    drive_run(-1, d, ve);
    n_cmp++;
    if (d != NV * P) begin
      n_fail++; $display("FAIL midrst_latency: got %0d want %0d", d, NV * P);
    end
    n_cmp++;
    if (fail_cnt !== 8'd0 || pass !== 1'b1) begin
      n_fail++; $display("FAIL midrst_result: got cnt=%0d pass=%b want 0/1",
                         fail_cnt, pass);
    end
  endtask

  task automatic test_random_faults();
    int d, ve, ec, ei;
    force_val = -1;
    for (int it = 0; it < 8; it++) begin
      foreach (flip[i]) flip[i] = ($urandom_range(3) == 0);
      expect_run(ec, ei);
      drive_run(-1, d, ve);
      n_cmp++;
      if (d != NV * P) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d",
                           it, d, NV * P);
      end
      n_cmp++;
      if (fail_cnt !== 8'(ec) || fail_idx !== 7'(ei)) begin
        n_fail++; $display("FAIL rand%0d_cnt_idx: got %0d/%0d want %0d/%0d",
                           it, fail_cnt, fail_idx, ec, ei);
      end
      n_cmp++;
      if (pass !== (ec == 0) || s_cnt !== 1'(ec > 0)) begin
        n_fail++; $display("FAIL rand%0d_pass_sat: got %b/%0d want %b/%0d",
                           it, pass, s_cnt, ec == 0, ec > 0);
      end
    end
    foreach (flip[i]) flip[i] = 1'b0;
  endtask

`ifdef HW1_1_EXHAUSTIVE_EN
  task automatic test_exhaustive();
    int d, ve, ones;
    force_val = -1;
    drive_run(-1, d, ve);
    n_cmp++;
    if (d != 128 * P || pass !== 1'b1) begin
      n_fail++; $display("FAIL exh_good: got lat=%0d pass=%b want %0d/1",
                         d, pass, 128 * P);
    end
    ones = 0;
    for (int v = 0; v < 128; v++) if (gate_model(7'(v))) ones++;
    force_val = 0;
    drive_run(-1, d, ve);
    n_cmp++;
    if (fail_cnt !== 8'(ones)) begin
      n_fail++; $display("FAIL exh_stuck0: got %0d want %0d", fail_cnt, ones);
    end
    force_val = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_good_gate();
    test_faulty_gate();
    test_start_while_busy();
    test_reset_mid_run();
    test_random_faults();
`ifdef HW1_1_EXHAUSTIVE_EN
    test_exhaustive();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
